// File: rtl/ram_16x8_sp.sv
// 16x8 single-port scratchpad RAM, write-first, synchronous active-low clear of array and output.
// Read data registered: one clock after addr; no handshake, one access completes every cycle.
module ram_16x8_sp #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_en,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_data_out <= '0;
        end else if (write_en) begin
            r_mem[addr] <= data_in;
            // Write-through: the word being written is what the port returns.
            r_data_out  <= data_in;
        end else begin
            r_data_out  <= r_mem[addr];
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_ram_16x8_sp.sv
// Directed bench for ram_16x8_sp: reset clear, write-through, aliasing, boundaries, latency, mid-run reset.
module tb_ram_16x8_sp;

    logic       clk;
    logic       rst_n;
    logic [3:0] addr;
    logic [7:0] data_in;
    logic       write_en;
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    ram_16x8_sp #(.DATA_W(8), .ADDR_W(4), .DEPTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] exp);
        total++;
        assert (data_out === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, data_out, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        rst_n = 1'b1; write_en = 1'b1; addr = a; data_in = d;
        tick();
    endtask

    task automatic rd(input logic [3:0] a);
        rst_n = 1'b1; write_en = 1'b0; addr = a; data_in = 8'h00;
        tick();
    endtask

    initial begin
        // Reset held two clocks with a write request that must be ignored.
        rst_n = 1'b0; write_en = 1'b1; addr = 4'd4; data_in = 8'hFF;
        tick();
        check("reset_cycle1", 8'h00);
        tick();
        check("reset_cycle2", 8'h00);

        for (int a = 0; a < 16; a++) begin
            rd(a[3:0]);
            check($sformatf("cleared_addr%0d", a), 8'h00);
        end

        wr(4'd4, 8'hA5);
        check("write_through_a4", 8'hA5);
        rd(4'd4);
        check("read_a4_first", 8'hA5);
        tick();
        check("read_a4_hold", 8'hA5);

        wr(4'd2, 8'h3C);
        check("write_through_a2", 8'h3C);
        rd(4'd2);
        check("read_a2", 8'h3C);
        rd(4'd4);
        check("no_alias_a4", 8'hA5);

        wr(4'd15, 8'h11);
        check("write_a15_first", 8'h11);
        wr(4'd15, 8'h22);
        check("write_a15_second", 8'h22);
        rd(4'd15);
        check("last_write_wins_a15", 8'h22);

        wr(4'd0, 8'h5A);
        check("write_a0", 8'h5A);
        rd(4'd0);
        check("read_a0", 8'h5A);
        rd(4'd15);
        check("a15_after_a0_write", 8'h22);

        // Address change between edges must not disturb the registered output.
        rd(4'd2);
        check("latency_pre_a2", 8'h3C);
        #3;
        addr = 4'd4;
        #1;
        check("latency_mid_cycle_hold", 8'h3C);
        tick();
        check("latency_after_edge_a4", 8'hA5);

        // One-clock reset pulse carrying a write that must be discarded.
        rst_n = 1'b0; write_en = 1'b1; addr = 4'd2; data_in = 8'h77;
        tick();
        check("midrun_reset_out", 8'h00);
        rd(4'd2);
        check("midrun_reset_a2", 8'h00);
        rd(4'd4);
        check("midrun_reset_a4", 8'h00);
        rd(4'd15);
        check("midrun_reset_a15", 8'h00);
        rd(4'd0);
        check("midrun_reset_a0", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
